latch_write_sequencer: RTL and testbench
========================================

# latch_write_sequencer

- Initiator side of the latch write interface.
- Accepts write requests over a valid/ready handshake and drives the shared data bus plus one-hot enables of a bank of level-sensitive latches.
- Each write is a guaranteed setup / enable-pulse / hold sequence, so latch enables never glitch or overlap.
- Sits between the control-path register logic and the latch bank.

## Interface
- DATA_W, 8, width of latch data bus
- NUM_LATCH, 4, number of latches driven (>=1; need not be a power of two)
- SETUP_CYC, 1, cycles data is stable before enable rises (>=1)
- PULSE_CYC, 2, cycles enable is high (>=1)
- HOLD_CYC, 1, cycles data is held after enable falls (>=1)
- ADDR_W, localparam = max(1, $clog2(NUM_LATCH))

Ports (clock and reset first):
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-low
- req_valid  input  1  write request present
- req_ready  output  1  sequencer can accept a request
- req_addr  input  ADDR_W  target latch index
- req_data  input  DATA_W  value to write
- lat_data  output  DATA_W  registered data bus to all latches
- lat_en  output  NUM_LATCH  registered one-hot latch enables
- busy  output  1  sequence in progress (state != IDLE)
- done  output  1  one-cycle pulse on last HOLD cycle
- err  output  1  one-cycle pulse for out-of-range address

## Operation
- States: IDLE, SETUP, PULSE, HOLD, ERR.
- req_ready = (state == IDLE) && reset. It is combinational and is 0 while reset is low.
- Accept = req_valid && req_ready at a rising edge. Addr/data are captured on that edge.
- IDLE -> SETUP on accept with req_addr < NUM_LATCH.
  - lat_data loads req_data.
  - lat_en is all zero.
- IDLE -> ERR on accept with req_addr >= NUM_LATCH.
  - ERR lasts 1 cycle with err = 1, then goes to IDLE.
  - lat_data and lat_en are unchanged.
- SETUP lasts SETUP_CYC cycles, then -> PULSE.
- PULSE lasts PULSE_CYC cycles with lat_en = 1 << addr. All other bits are 0.
- PULSE -> HOLD: lat_en returns to 0 and lat_data is unchanged.
- HOLD lasts HOLD_CYC cycles. done = 1 on its final cycle, then -> IDLE.
- lat_data retains the last written value in IDLE and is never cleared except by reset.
- At most one lat_en bit is high at any cycle. lat_en is never high outside PULSE.
- A phase down-counter of width $clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1) loads (N-1) on phase entry and advances the phase at 0.

## Timing
- Reset values: state IDLE, lat_data 0, lat_en 0, busy 0, done 0, err 0. req_ready is 0 while reset is low and 1 on the first cycle after reset is released.
- Accept at edge T0:
  - SETUP occupies cycles T0+1 .. T0+SETUP_CYC.
  - lat_en is high for the next PULSE_CYC cycles.
  - done is high in cycle T0+SETUP_CYC+PULSE_CYC+HOLD_CYC.
  - req_ready is high again in the following cycle.
- Minimum request spacing is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles. For an error request the spacing is 2 cycles.
- Requests are not accepted while busy.
  - req_valid may stay high.
  - The held request is accepted on the first IDLE cycle.
- Reset low at any edge mid-sequence:
  - Next cycle: state is IDLE and lat_en is 0, including in PULSE.
  - lat_data is 0.
  - No done or err pulse is produced for the aborted write.
- done and err never assert in the same cycle.

## Structure
- Shared package latch_seq_pkg:
  - typedef enum logic [2:0] latch_seq_state_t {IDLE, SETUP, PULSE, HOLD, ERR}.
  - Function for the one-hot decode of an index.
- Sub-module latch_phase_timer: loadable down-counter with a zero flag. Its inputs are clk, reset, load, load_val and its output is zero.
- Top level holds the FSM, address/data capture registers, the one-hot decode and the range check.

## Test plan
- Default params: reset low 3 cycles, release → in the first cycle req_ready = 1; lat_en = 0, lat_data = 0 until a request.
- Accept addr=2, data=8'hA5 at T0 → lat_data = A5 from T0+1; lat_en = 4'b0100 at T0+2..T0+3; done at T0+4; req_ready = 1 at T0+5.
- req_valid held high with addr 0, 1, 3 back-to-back → writes spaced 5 cycles apart; lat_en shows 0001, 0010, 1000 in turn, never overlapping; 3 done pulses.
- NUM_LATCH=3, addr=3 → err = 1 one cycle after accept; lat_en stays 0; no done; ready returns next cycle.
- Reset pulled low during the second PULSE cycle → next cycle lat_en = 0, lat_data = 0, busy = 0; no done pulse.
- SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2, data 8'h3C → lat_en high for exactly 1 cycle at T0+4; done at T0+6; lat_data = 3C throughout.

Source files
------------

// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg: shared FSM state type and one-hot decode helper for the latch write sequencer
package latch_seq_pkg;
  localparam int ONEHOT_W = 32;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, ERR} latch_seq_state_t;
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [4:0] idx);
    return {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/latch_write_sequencer_timer.sv
// latch_phase_timer: loadable down-counter that parks at zero and flags it
module latch_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] r_cnt;
  // load has priority so a phase entry on the terminal cycle restarts cleanly
  always_ff @(posedge clk) begin
    if (!reset) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign zero = (r_cnt == '0);
endmodule

// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: turns valid/ready write requests into setup/pulse/hold latch write sequences
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_LATCH = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC = 1,
  localparam int ADDR_W = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [DATA_W-1:0] lat_data,
  output logic [NUM_LATCH-1:0] lat_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                   : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);
  latch_seq_state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [NUM_LATCH-1:0] r_en;
  logic [ONEHOT_W-1:0] w_dec_full;
  logic [NUM_LATCH-1:0] w_dec;
  logic w_accept, w_in_range, w_zero, w_load;
  logic [CW-1:0] w_load_val;
  assign w_in_range = {1'b0, req_addr} < (ADDR_W+1)'(NUM_LATCH);
  assign w_dec_full = onehot(5'(r_addr));
  assign w_dec = w_dec_full[NUM_LATCH-1:0];
  latch_phase_timer #(.W(CW)) u_timer (
    .clk(clk), .reset(reset), .load(w_load), .load_val(w_load_val), .zero(w_zero)
  );
  // state register; reset aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // phase advance: each timed phase moves on once its counter reaches zero
  always_comb begin
    w_next = (r_state == IDLE)  ? (w_accept ? (w_in_range ? SETUP : ERR) : IDLE) :
             (r_state == SETUP) ? (w_zero ? PULSE : SETUP) :
             (r_state == PULSE) ? (w_zero ? HOLD : PULSE) :
             (r_state == HOLD)  ? (w_zero ? IDLE : HOLD) : IDLE;
  end
  // handshake, status pulses and phase-timer reloads on every phase entry
  always_comb begin
    req_ready = (r_state == IDLE) && reset;
    w_accept = req_valid && req_ready;
    busy = (r_state != IDLE);
    done = (r_state == HOLD) && w_zero;
    err = (r_state == ERR);
    w_load = w_accept || (((r_state == SETUP) || (r_state == PULSE)) && w_zero);
    w_load_val = (r_state == IDLE) ? S_LD : (r_state == SETUP) ? P_LD : H_LD;
  end
  // request capture and registered latch bus; enables derive from next state so they never glitch
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_en <= '0;
    end else begin
      if (w_accept) r_addr <= req_addr;
      if (w_accept && w_in_range) r_data <= req_data;
      r_en <= (w_next == PULSE) ? w_dec : '0;
    end
  end
  assign lat_data = r_data;
  assign lat_en = r_en;
endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb_latch_write_sequencer: directed checks of latch write sequencing across three parameterisations
module tb_latch_write_sequencer;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic v0 = 0, v1 = 0, v2 = 0;
  logic [1:0] a0 = 0, a1 = 0, a2 = 0;
  logic [7:0] d0 = 0, d1 = 0, d2 = 0;
  logic r0, r1, r2, b0, b1, b2, dn0, dn1, dn2, e0, e1, e2;
  logic [7:0] ld0, ld1, ld2;
  logic [3:0] le0, le2;
  logic [2:0] le1;

  latch_write_sequencer dut0 (.clk(clk), .reset(rst_n), .req_valid(v0), .req_ready(r0), .req_addr(a0),
    .req_data(d0), .lat_data(ld0), .lat_en(le0), .busy(b0), .done(dn0), .err(e0));
  latch_write_sequencer #(.NUM_LATCH(3)) dut1 (.clk(clk), .reset(rst_n), .req_valid(v1), .req_ready(r1),
    .req_addr(a1), .req_data(d1), .lat_data(ld1), .lat_en(le1), .busy(b1), .done(dn1), .err(e1));
  latch_write_sequencer #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut2 (.clk(clk), .reset(rst_n),
    .req_valid(v2), .req_ready(r2), .req_addr(a2), .req_data(d2), .lat_data(ld2), .lat_en(le2),
    .busy(b2), .done(dn2), .err(e2));

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got %b exp 0", r0); end
    rst_n = 1;
    #1;
    n_chk++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_first got %b exp 1", r0); end
    n_chk++; if ({le0, ld0, b0, dn0, e0} !== 15'h0) begin n_fail++;
      $display("FAIL reset_outputs got en=%b data=%h busy=%b done=%b err=%b exp all 0", le0, ld0, b0, dn0, e0); end
    @(negedge clk);
    n_chk++; if ({le0, ld0} !== 12'h0) begin n_fail++; $display("FAIL idle_outputs got en=%b data=%h exp 0", le0, ld0); end
  endtask

  task automatic test_single_write();
    logic [3:0] exp_en [1:5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic exp_dn [1:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    v0 = 1; a0 = 2; d0 = 8'hA5;
    @(negedge clk);
    v0 = 0;
    for (int k = 1; k <= 5; k++) begin
      n_chk++; if (le0 !== exp_en[k] || dn0 !== exp_dn[k] || ld0 !== 8'hA5) begin n_fail++;
        $display("FAIL write_T0+%0d got en=%b done=%b data=%h exp en=%b done=%b data=a5", k, le0, dn0, ld0, exp_en[k], exp_dn[k]); end
      if (k < 5) @(negedge clk);
    end
    n_chk++; if (r0 !== 1'b1 || b0 !== 1'b0) begin n_fail++; $display("FAIL write_ready_back got ready=%b busy=%b exp 1/0", r0, b0); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] addrs [3] = '{2'd0, 2'd1, 2'd3};
    logic [3:0] ens [3] = '{4'b0001, 4'b0010, 4'b1000};
    int dones = 0;
    v0 = 1;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %b exp 1", i, r0); end
      a0 = addrs[i]; d0 = 8'h10 + 8'(i);
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (k == 4) v0 = (i < 2);
        dones += int'(dn0);
        n_chk++; if (le0 !== ((k == 2 || k == 3) ? ens[i] : 4'b0000)) begin n_fail++;
          $display("FAIL b2b_en_%0d_T0+%0d got %b exp %b", i, k, le0, (k == 2 || k == 3) ? ens[i] : 4'b0000); end
      end
    end
    v0 = 0;
    n_chk++; if (dones != 3) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 3", dones); end
  endtask

  task automatic test_err();
    v1 = 1; a1 = 2; d1 = 8'h5A;
    @(negedge clk);
    v1 = 0;
    repeat (4) @(negedge clk);
    n_chk++; if (r1 !== 1'b1 || ld1 !== 8'h5A) begin n_fail++; $display("FAIL err_prewrite got ready=%b data=%h exp 1/5a", r1, ld1); end
    v1 = 1; a1 = 3; d1 = 8'hFF;
    @(negedge clk);
    v1 = 0;
    n_chk++; if (e1 !== 1'b1 || dn1 !== 1'b0 || le1 !== 3'b000 || ld1 !== 8'h5A) begin n_fail++;
      $display("FAIL err_pulse got err=%b done=%b en=%b data=%h exp 1/0/000/5a", e1, dn1, le1, ld1); end
    @(negedge clk);
    n_chk++; if (e1 !== 1'b0 || r1 !== 1'b1 || dn1 !== 1'b0 || le1 !== 3'b000) begin n_fail++;
      $display("FAIL err_recover got err=%b ready=%b done=%b en=%b exp 0/1/0/000", e1, r1, dn1, le1); end
  endtask

  task automatic test_reset_abort();
    v0 = 1; a0 = 1; d0 = 8'h77;
    @(negedge clk);
    v0 = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (le0 !== 4'b0010) begin n_fail++; $display("FAIL abort_in_pulse got %b exp 0010", le0); end
    rst_n = 0;
    @(negedge clk);
    n_chk++; if (le0 !== 4'b0 || ld0 !== 8'h0 || b0 !== 1'b0 || dn0 !== 1'b0 || r0 !== 1'b0) begin n_fail++;
      $display("FAIL abort_state got en=%b data=%h busy=%b done=%b ready=%b exp 0/00/0/0/0", le0, ld0, b0, dn0, r0); end
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (dn0 !== 1'b0 || r0 !== 1'b1) begin n_fail++; $display("FAIL abort_after_%0d got done=%b ready=%b exp 0/1", k, dn0, r0); end
      @(negedge clk);
    end
  endtask

  task automatic test_timing();
    logic [3:0] exp_en [1:7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic exp_dn [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    v2 = 1; a2 = 1; d2 = 8'h3C;
    @(negedge clk);
    v2 = 0;
    for (int k = 1; k <= 7; k++) begin
      n_chk++; if (le2 !== exp_en[k] || dn2 !== exp_dn[k] || ld2 !== 8'h3C || r2 !== (k == 7)) begin n_fail++;
        $display("FAIL timing_T0+%0d got en=%b done=%b data=%h ready=%b exp en=%b done=%b data=3c ready=%b",
                 k, le2, dn2, ld2, r2, exp_en[k], exp_dn[k], k == 7); end
      if (k < 7) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_back_to_back();
    test_err();
    test_timing();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
